// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first, stalling the pipeline until each access completes
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReqF,
    input  logic [AW-1:0] PCF,
    output logic [DW-1:0] InstrF,
    input  logic          DReqM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          BusStall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);
    typedef enum logic [1:0] {IDLE, DWAIT, IWAIT} stateT;
    stateT state, stateNext;
    logic dDone, iDone, dStall, iStall, ackD, ackI, start;
    logic [AW-1:0] iTag;
    assign dStall = DReqM & ~dDone;
    assign iStall = IReqF & ~(iDone & (iTag == PCF));
    assign BusStall = dStall | iStall;
    assign ackD = (state == DWAIT) & mem_ack;
    assign ackI = (state == IWAIT) & mem_ack;
    assign start = (state == IDLE) & BusStall;
    always_comb begin
        stateNext = state;
        if (state == IDLE)
            stateNext = dStall ? DWAIT : iStall ? IWAIT : IDLE;
        else if (mem_ack)
            stateNext = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            InstrF    <= '0;
            ReadDataM <= '0;
            iTag      <= '0;
            dDone     <= 1'b0;
            iDone     <= 1'b0;
        end else begin
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= dStall & MemWriteM;
                mem_addr  <= dStall ? ALUResultM : PCF;
                mem_wdata <= dStall ? WriteDataM : '0;
            end else if (ackD | ackI) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
            if (ackD & ~mem_we)
                ReadDataM <= mem_rdata;
            if (ackI) begin
                InstrF <= mem_rdata;
                iTag   <= mem_addr;
            end
            dDone <= ackD | (dDone & BusStall);
            iDone <= ackI | (iDone & BusStall);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model and memory
module tb_mem_port_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic IReqF = 1'b0, DReqM = 1'b0, MemWriteM = 1'b0, mem_ack = 1'b0;
    logic [31:0] PCF = '0, ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
    logic [31:0] InstrF, ReadDataM, mem_addr, mem_wdata;
    logic BusStall, mem_req, mem_we;
    int tests = 0, fails = 0;
    int fixedWait = -1, memLeft = 0, stallCnt = 0;
    bit memBusy = 0;
    logic [31:0] memArr [logic [31:0]];
    bit mBusy, mIsData, mWe, mDDone, mIDone;
    logic [31:0] mAddr, mWdata, mITag, mInstr, mRead;
    logic [31:0] saved;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset), .IReqF(IReqF), .PCF(PCF), .InstrF(InstrF),
        .DReqM(DReqM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .BusStall(BusStall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : ({a[15:0], ~a[15:0]} ^ 32'h1357_9BDF);
    endfunction

    function automatic logic expStall();
        return (DReqM & ~mDDone) | (IReqF & ~(mIDone & (mITag == PCF)));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        {mBusy, mIsData, mWe, mDDone, mIDone} = '0;
        {mAddr, mWdata, mITag, mInstr, mRead} = '0;
        memBusy = 0;
        memLeft = 0;
    endtask

    task automatic checkOutputs();
        check("BusStall", BusStall, expStall());
        check("mem_req", mem_req, mBusy);
        check("mem_we", mem_we, mBusy & mWe);
        check("mem_addr", mem_addr, mBusy ? mAddr : 32'h0);
        check("mem_wdata", mem_wdata, mBusy ? mWdata : 32'h0);
        check("InstrF", InstrF, mInstr);
        check("ReadDataM", ReadDataM, mRead);
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic stepCycle();
        logic st, ack, wWe, ackD, ackI, startD, startI;
        logic [31:0] wAddr, wData;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (!memBusy) begin
                memBusy = 1;
                memLeft = fixedWait >= 0 ? fixedWait : $urandom_range(0, 3);
            end
            if (memLeft == 0) begin
                mem_ack = 1'b1;
                mem_rdata = memRead(mem_addr);
            end
        end
        #1;
        checkOutputs();
        st = expStall();
        stallCnt += int'(st);
        ack = mem_ack;
        wAddr = mem_addr;
        wData = mem_wdata;
        wWe = mem_we;
        @(posedge clk);
        ackD = mBusy & ack & mIsData;
        ackI = mBusy & ack & ~mIsData;
        startD = ~mBusy & DReqM & ~mDDone;
        startI = ~mBusy & ~startD & st;
        if (ackD && !mWe) mRead = memRead(mAddr);
        if (ackI) begin
            mInstr = memRead(mAddr);
            mITag = mAddr;
        end
        mDDone = ackD | (mDDone & st);
        mIDone = ackI | (mIDone & st);
        if (ackD | ackI) mBusy = 0;
        if (startD) begin
            {mBusy, mIsData, mWe} = {2'b11, MemWriteM};
            mAddr = ALUResultM;
            mWdata = WriteDataM;
        end
        if (startI) begin
            {mBusy, mIsData, mWe} = 3'b100;
            mAddr = PCF;
            mWdata = '0;
        end
        if (ack) begin
            memBusy = 0;
            if (wWe) memArr[wAddr] = wData;
        end else if (memBusy) memLeft--;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic runUntilFree(input int limit);
        stallCnt = 0;
        for (int i = 0; i < limit; i++) begin
            stepCycle();
            if (!BusStall) return;
        end
        check("stall_timeout", BusStall, 1'b0);
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutputs();
        @(negedge clk);
        reset = 1'b0;

        fixedWait = 0;
        IReqF = 1'b1;
        PCF = 32'h100;
        run(1);
        check("fetch_req", mem_req, 1'b1);
        check("fetch_addr", mem_addr, 32'h100);
        run(1);
        check("fetch_instr", InstrF, memRead(32'h100));
        check("fetch_stall", BusStall, 1'b0);
        IReqF = 1'b0;
        run(2);

        fixedWait = 2;
        IReqF = 1'b1;
        PCF = 32'h300;
        DReqM = 1'b1;
        ALUResultM = 32'h2000;
        stallCnt = 0;
        stepCycle();
        check("both_first_addr", mem_addr, 32'h2000);
        check("both_first_we", mem_we, 1'b0);
        for (int i = 0; i < 20 && BusStall; i++) stepCycle();
        check("both_stall_cycles", stallCnt, 4 + 2 * fixedWait);
        check("both_read", ReadDataM, memRead(32'h2000));
        check("both_instr", InstrF, memRead(32'h300));
        {IReqF, DReqM} = 2'b00;
        run(2);

        fixedWait = 1;
        saved = ReadDataM;
        {DReqM, MemWriteM} = 2'b11;
        ALUResultM = 32'h40;
        WriteDataM = 32'hDEAD_BEEF;
        run(1);
        check("store_we1", mem_we, 1'b1);
        check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        run(1);
        check("store_we2", mem_we, 1'b1);
        run(1);
        check("store_stall", BusStall, 1'b0);
        check("store_rd_kept", ReadDataM, saved);
        check("store_written", memRead(32'h40), 32'hDEAD_BEEF);
        {DReqM, MemWriteM} = 2'b00;
        run(2);

        fixedWait = 2;
        IReqF = 1'b1;
        PCF = 32'h100;
        run(2);
        PCF = 32'h200;
        run(2);
        check("redirect_stall", BusStall, 1'b1);
        check("redirect_old", InstrF, memRead(32'h100));
        runUntilFree(12);
        check("redirect_new", InstrF, memRead(32'h200));
        IReqF = 1'b0;
        run(2);

        fixedWait = 3;
        DReqM = 1'b1;
        ALUResultM = 32'h500;
        run(2);
        reset = 1'b1;
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_instr", InstrF, 32'h0);
        check("rst_read", ReadDataM, 32'h0);
        check("rst_stall", BusStall, 1'b1);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        run(1);
        check("rst_reissue", mem_addr, 32'h500);
        runUntilFree(12);
        check("rst_read_after", ReadDataM, memRead(32'h500));
        DReqM = 1'b0;
        run(2);

        fixedWait = 5;
        DReqM = 1'b1;
        ALUResultM = 32'h600;
        runUntilFree(15);
        check("slow_stall_cycles", stallCnt, 2 + fixedWait);
        check("slow_read", ReadDataM, memRead(32'h600));
        DReqM = 1'b0;
        run(2);

        fixedWait = -1;
        for (int c = 0; c < 3000; c++) begin
            if (!expStall() || $urandom_range(0, 9) == 0) begin
                IReqF = ($urandom_range(0, 3) != 0);
                PCF = 32'h100 + 32'(4 * $urandom_range(0, 3));
                DReqM = ($urandom_range(0, 2) == 0);
                MemWriteM = $urandom_range(0, 1) == 1;
                ALUResultM = 32'h2000 + 32'(4 * $urandom_range(0, 3));
                WriteDataM = $urandom;
            end
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
